// File: rtl/vector_op_sequencer.sv
// Sequences a VLEN-element vector operation through a LANES-wide combinational ALU,
// one chunk per cycle, and holds the assembled result until the consumer accepts it.
module vector_op_sequencer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LANES         = 6,
  parameter int unsigned SELECTOR_SIZE = 3,
  parameter int unsigned CHUNKS        = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [SELECTOR_SIZE-1:0]              req_op,
  input  logic [CHUNKS*LANES*DATA_WIDTH-1:0]    req_src1,
  input  logic [CHUNKS*LANES*DATA_WIDTH-1:0]    req_src2,
  output logic [SELECTOR_SIZE-1:0]              alu_selector,
  output logic [LANES*DATA_WIDTH-1:0]           alu_operand1,
  output logic [LANES*DATA_WIDTH-1:0]           alu_operand2,
  input  logic [LANES*DATA_WIDTH-1:0]           alu_result,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [CHUNKS*LANES*DATA_WIDTH-1:0]    rsp_data,
  output logic                                  busy
);

  localparam int unsigned VLEN   = CHUNKS * LANES;
  localparam int unsigned VecW   = VLEN * DATA_WIDTH;
  localparam int unsigned ChunkW = LANES * DATA_WIDTH;
  localparam int unsigned CntW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [CntW-1:0]          LastCnt = CntW'(CHUNKS - 1);
  localparam logic [SELECTOR_SIZE-1:0] SelPass = SELECTOR_SIZE'(5);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [SELECTOR_SIZE-1:0] op_q, op_d;
  logic [VecW-1:0]          src1_q, src1_d;
  logic [VecW-1:0]          src2_q, src2_d;
  logic [VecW-1:0]          rsp_data_q, rsp_data_d;
  logic                     ready_en_q;
  logic [31:0]              chunk_off;

  assign chunk_off = 32'(cnt_q) * 32'(ChunkW);

  // Holds req_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          src1_d  = req_src1;
          src2_d  = req_src2;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        rsp_data_d[chunk_off +: ChunkW] = alu_result;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outside RUN the ALU is parked on pass-operand1 with zero operands.
  always_comb begin
    alu_selector = SelPass;
    alu_operand1 = '0;
    alu_operand2 = '0;
    if (state_q == StRun) begin
      alu_selector = op_q;
      alu_operand1 = src1_q[chunk_off +: ChunkW];
      alu_operand2 = src2_q[chunk_off +: ChunkW];
    end
  end

  assign req_ready = ready_en_q && (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Bench for vector_op_sequencer: directed and random requests through a behavioural
// vector ALU, checked against a whole-vector reference model.
module tb_vector_op_sequencer;

  localparam int DW     = 8;
  localparam int LANES  = 6;
  localparam int SS     = 3;
  localparam int CHUNKS = 4;
  localparam int VLEN   = CHUNKS * LANES;
  localparam int VW     = VLEN * DW;
  localparam int CW     = LANES * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [SS-1:0] req_op = '0;
  logic [VW-1:0] req_src1 = '0;
  logic [VW-1:0] req_src2 = '0;
  logic [SS-1:0] alu_selector;
  logic [CW-1:0] alu_operand1;
  logic [CW-1:0] alu_operand2;
  logic [CW-1:0] alu_result;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [VW-1:0] rsp_data;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vector_op_sequencer #(
    .DATA_WIDTH(DW), .LANES(LANES), .SELECTOR_SIZE(SS), .CHUNKS(CHUNKS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .alu_selector(alu_selector), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  function automatic logic [DW-1:0] alu_elem(input logic [SS-1:0] op,
                                             input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return p[DW-1:0];
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a;
      3'b110:  return b;
      default: return a ^ b;
    endcase
  endfunction

  // Behavioural stand-in for the team's vector ALU.
  always_comb begin
    alu_result = '0;
    for (int l = 0; l < LANES; l++)
      alu_result[l*DW +: DW] = alu_elem(alu_selector, alu_operand1[l*DW +: DW],
                                        alu_operand2[l*DW +: DW]);
  end

  function automatic logic [VW-1:0] model(input logic [SS-1:0] op,
                                          input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < VLEN; i++) r[i*DW +: DW] = alu_elem(op, a[i*DW +: DW], b[i*DW +: DW]);
    return r;
  endfunction

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < VLEN; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int w = 0; w < VW / 32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_parked(input string tag);
    check({tag, "_sel"}, VW'(alu_selector), VW'(3'b101));
    check({tag, "_op1"}, VW'(alu_operand1), '0);
    check({tag, "_op2"}, VW'(alu_operand2), '0);
    check({tag, "_busy"}, VW'(busy), '0);
    check({tag, "_valid"}, VW'(rsp_valid), '0);
  endtask

  // Called at a negedge; returns at the negedge after DONE is entered, or at the negedge
  // of chunk abort_chunk when that is in range.
  task automatic run_req(input logic [SS-1:0] op, input logic [VW-1:0] s1,
                         input logic [VW-1:0] s2, input int abort_chunk, input bit mutate,
                         output logic [VW-1:0] exp);
    int waitc;
    exp = model(op, s1, s2);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = s1;
    req_src2  = s2;
    waitc     = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      check("accept_timeout", VW'(req_ready), VW'(1));
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 0; k < CHUNKS; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mutate) begin
        req_src1 = ~s1;
        req_src2 = ~s2;
        req_op   = op ^ 3'b011;
      end
      if (k == abort_chunk) return;
      check("run_busy", VW'(busy), VW'(1));
      check("run_valid", VW'(rsp_valid), '0);
      check("run_ready", VW'(req_ready), '0);
      check("run_sel", VW'(alu_selector), VW'(op));
      check("run_op1", VW'(alu_operand1), VW'(s1[k*CW +: CW]));
      check("run_op2", VW'(alu_operand2), VW'(s2[k*CW +: CW]));
    end
    @(negedge clk);
    check("done_valid", VW'(rsp_valid), VW'(1));
    check("done_busy", VW'(busy), VW'(1));
    check("done_data", rsp_data, exp);
  endtask

  // Called at a negedge in DONE; stalls for hold cycles, then completes the handshake.
  task automatic finish_rsp(input int hold, input logic [VW-1:0] exp);
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", VW'(rsp_valid), VW'(1));
      check("hold_data", rsp_data, exp);
      check("hold_ready", VW'(req_ready), '0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_ready", VW'(req_ready), VW'(1));
    check("post_data", rsp_data, exp);
    check_parked("post");
  endtask

  initial begin
    logic [VW-1:0] exp, s1, s2, n1, n2;
    logic [SS-1:0] op;

    #3;
    check("rst_ready", VW'(req_ready), '0);
    check("rst_data", rsp_data, '0);
    check_parked("rst");
    #9;
    rst_n = 1'b1;
    #1;
    check("rel_ready_early", VW'(req_ready), '0);
    @(negedge clk);
    check("rel_ready", VW'(req_ready), VW'(1));

    // Add: element i = i + 1
    for (int i = 0; i < VLEN; i++) s1[i*DW +: DW] = DW'(i);
    run_req(3'b000, s1, fill(8'd1), CHUNKS, 1'b0, exp);
    for (int i = 0; i < VLEN; i++) n1[i*DW +: DW] = DW'(i + 1);
    check("add_data", rsp_data, n1);
    finish_rsp(0, n1);

    // Backpressure: 3*5 = 15, held for 10 cycles
    run_req(3'b010, fill(8'd3), fill(8'd5), CHUNKS, 1'b0, exp);
    check("mul_data", rsp_data, fill(8'd15));
    finish_rsp(10, fill(8'd15));

    // Back-to-back: second request pending while DONE must wait for IDLE
    run_req(3'b001, fill(8'd20), fill(8'd7), CHUNKS, 1'b0, exp);
    check("sub_data", rsp_data, fill(8'd13));
    n1 = rand_vec();
    n2 = rand_vec();
    req_valid = 1'b1;
    req_op    = 3'b110;
    req_src1  = n1;
    req_src2  = n2;
    finish_rsp(2, fill(8'd13));
    run_req(3'b110, n1, n2, CHUNKS, 1'b0, exp);
    check("pass2_data", rsp_data, n2);
    finish_rsp(1, n2);

    // Wrap: 200 + 100 = 44 mod 256
    run_req(3'b000, fill(8'd200), fill(8'd100), CHUNKS, 1'b0, exp);
    check("wrap_data", rsp_data, fill(8'd44));
    finish_rsp(0, fill(8'd44));

    // Sampling: request inputs change during RUN
    s1 = rand_vec();
    s2 = rand_vec();
    run_req(3'b000, s1, s2, CHUNKS, 1'b1, exp);
    finish_rsp(1, exp);

    // Abort: reset during chunk 2
    run_req(3'b000, rand_vec(), rand_vec(), 2, 1'b0, exp);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", VW'(req_ready), '0);
    check("abort_data", rsp_data, '0);
    check_parked("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_novalid", VW'(rsp_valid), '0);
      check("abort_rdy", VW'(req_ready), VW'(1));
    end

    // Random requests with random backpressure
    for (int t = 0; t < 12; t++) begin
      op = SS'($urandom_range(0, 7));
      s1 = rand_vec();
      s2 = rand_vec();
      run_req(op, s1, s2, CHUNKS, 1'b0, exp);
      finish_rsp(int'($urandom_range(0, 3)), exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vector_op_sequencer.md
VECTOR_OP_SEQUENCER -- requirements
Module: vector_op_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_WIDTH, 8, element width in bits.
REQ-002 LANES, 6, elements per vector ALU operation.
REQ-003 SELECTOR_SIZE, 3, width of the ALU operation selector.
REQ-004 CHUNKS, 4, number of LANES-wide chunks per full vector; VLEN = CHUNKS*LANES elements.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low. Ports (name, direction, width, meaning) follow.
REQ-006 clk, in, 1, rising-edge clock.
REQ-007 rst_n, in, 1, asynchronous active-low reset.
REQ-008 req_valid, in, 1, a request is present.
REQ-009 req_ready, out, 1, the block can accept a request.
REQ-010 req_op, in, SELECTOR_SIZE, the ALU operation code.
REQ-011 req_src1 and req_src2, in, VLEN*DATA_WIDTH each, the source vectors; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 alu_selector, out, SELECTOR_SIZE, the selector driven to the vector ALU.
REQ-013 alu_operand1 and alu_operand2, out, LANES*DATA_WIDTH each, the current chunk; lane 0 is in the LSBs.
REQ-014 alu_result, in, LANES*DATA_WIDTH, the packed result from the combinational vector ALU.
REQ-015 rsp_valid, out, 1, the result vector is available.
REQ-016 rsp_ready, in, 1, the consumer accepts the result.
REQ-017 rsp_data, out, VLEN*DATA_WIDTH, the result vector, laid out the same way as the sources.
REQ-018 busy, out, 1, high in the RUN or DONE state.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted at a rising edge where req_valid && req_ready.
REQ-021 On acceptance, the block SHALL latch req_op, req_src1 and req_src2, clear the chunk counter cnt to 0, and enter RUN.
REQ-022 Inputs SHALL NOT be sampled outside an acceptance edge; changes to req_* during RUN/DONE have no effect.
REQ-023 In RUN, alu_selector SHALL equal the latched op; alu_operand1/2 SHALL equal elements [cnt*LANES +: LANES] of the latched src1/src2.
REQ-024 In each RUN cycle, the rising edge SHALL write alu_result into chunk cnt of the rsp_data register and increment cnt.
REQ-025 When cnt==CHUNKS-1 at that edge, the FSM SHALL go to DONE instead of incrementing cnt.
REQ-026 RUN SHALL last exactly CHUNKS cycles; rsp_valid rises CHUNKS cycles after the acceptance edge.
REQ-027 In DONE, rsp_valid SHALL be 1; on an edge with rsp_ready=1, the FSM SHALL return to IDLE.
REQ-028 A new request SHALL NOT be accepted in the same cycle as the response handshake, since req_ready is 0 in DONE.
REQ-029 rsp_valid SHALL stay high with rsp_data stable while rsp_ready=0, indefinitely.
REQ-030 rsp_data SHALL hold its value after the handshake until the first RUN write of the next request.
REQ-031 Outside RUN, alu_selector SHALL be 3'b101 (pass operand1), and alu_operand1/2 SHALL be all zero.
REQ-032 Op codes SHALL be forwarded unmodified; the block performs no arithmetic. Undefined codes (3'b111) are not trapped.
REQ-033 cnt SHALL be $clog2(CHUNKS) bits wide and never exceed CHUNKS-1; there is no wrap-around inside a request.

Reset
REQ-034 While rst_n=0, asynchronously: state=IDLE, cnt=0, latched op/src registers=0, rsp_data=0.
REQ-035 While rst_n=0, the outputs SHALL be req_ready=0, rsp_valid=0, busy=0, alu_selector=3'b101 and alu_operands=0.
REQ-036 req_ready SHALL rise at the first rising edge after rst_n deasserts.
REQ-037 Reset during RUN or DONE SHALL abort the operation; no partial result is ever signalled valid.

Verification (the bench connects the team's vector ALU to the alu_* ports)
REQ-038 Add test: op=000, src1 elements=i, src2 elements=1 (i=0..23) -> rsp_valid 4 cycles after acceptance, rsp_data element i = i+1.
REQ-039 Backpressure test: op=010 with all elements 3 and 5, rsp_ready held 0 for 10 cycles -> rsp_valid stays high and all elements stay 15; req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
REQ-040 Back-to-back test: a sub request (op=001, 20-7 -> 13) then an immediate second request (op=110) -> the second is accepted only in IDLE; the second result equals src2.
REQ-041 Wrap test: add 200+100 in 8 bits -> element = 44 (mod 256).
REQ-042 Abort test: rst_n pulsed low during chunk 2 of RUN -> rsp_valid never asserts, rsp_data=0, and req_ready=1 after reset release.
REQ-043 Sampling test: change req_src1 during RUN -> the result reflects the values latched at acceptance.
